// File: rtl/rgb_fade_pkg.sv
// Shared types and helpers for the fading RGB PWM generator.
package rgb_fade_pkg;

  // Per-channel fade direction; IDLE means duty has reached target.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } ch_state_t;

  // Channel index width; a single channel still needs a one-bit select.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_fade_channel.sv
// One PWM channel: holds duty/target/step, walks duty toward target once
// per PWM period with saturation at the target, and drives its waveform.
module rgb_fade_channel
  import rgb_fade_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 period_end,
  input  logic [PWM_WIDTH-1:0] cnt,
  input  logic                 wr,
  input  logic [PWM_WIDTH-1:0] wr_target,
  input  logic [PWM_WIDTH-1:0] wr_step,
  output logic                 pwm,
  output logic [PWM_WIDTH-1:0] duty,
  output logic                 done,
  output ch_state_t            state
);

  logic [PWM_WIDTH-1:0] target;
  logic [PWM_WIDTH-1:0] step;
  logic [PWM_WIDTH:0]   sum_w;
  logic [PWM_WIDTH:0]   diff_w;
  logic [PWM_WIDTH-1:0] stepped;

  // Next duty for a period update, computed one bit wider so the step
  // can neither wrap past all-ones nor underflow below zero.
  always_comb begin
    sum_w   = {1'b0, duty} + {1'b0, step};
    diff_w  = {1'b0, duty} - {1'b0, step};
    stepped = duty;
    if (duty < target) begin
      stepped = (sum_w >= {1'b0, target}) ? target : sum_w[PWM_WIDTH-1:0];
    end else if (duty > target) begin
      stepped = (diff_w[PWM_WIDTH] || (diff_w[PWM_WIDTH-1:0] <= target))
                ? target : diff_w[PWM_WIDTH-1:0];
    end
  end

  // Channel FSM and datapath. A config write takes priority over a period
  // update in the same cycle, so that period's step is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      step   <= '0;
      duty   <= '0;
      done   <= 1'b0;
      pwm    <= 1'b0;
      state  <= ST_IDLE;
    end else begin
      if (duty < target)      state <= ST_UP;
      else if (duty > target) state <= ST_DOWN;
      else                    state <= ST_IDLE;

      done <= 1'b0;
      if (wr) begin
        target <= wr_target;
        step   <= wr_step;
        if (wr_step == '0) duty <= wr_target;
      end else if (period_end && (duty != target)) begin
        duty <= stepped;
        done <= (stepped == target);
      end

      pwm <= enable && ((duty == '1) || (cnt < duty));
    end
  end

endmodule

// File: rtl/rgb_fade_pwm.sv
// N-channel PWM generator with hardware fading, feeding RGB LED driver
// PWM inputs. Holds the shared prescaler, PWM counter and config decode.
//
// Config handshake: a write happens on every clock edge where cfg_valid
// and cfg_ready are both high; cfg_ready is high whenever out of reset, so
// one write can be taken per cycle. Writes to a nonexistent channel are
// dropped and flagged by a one-cycle cfg_err pulse.
module rgb_fade_pwm
  import rgb_fade_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int PWM_WIDTH   = 8,
  parameter int PRESC_DIV   = 188,
  parameter int PRESC_WIDTH = 16,
  localparam int CHW        = chw(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CHW-1:0]              cfg_ch,
  input  logic [PWM_WIDTH-1:0]        cfg_target,
  input  logic [PWM_WIDTH-1:0]        cfg_step,
  output logic                        cfg_err,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic [NUM_CH*PWM_WIDTH-1:0] duty_out,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           done,
  output logic                        period_strobe
);

  localparam logic [PRESC_WIDTH-1:0] PRESC_LAST = PRESC_WIDTH'(PRESC_DIV - 1);

  logic [PRESC_WIDTH-1:0] presc;
  logic [PWM_WIDTH-1:0]   cnt;
  logic                   tick;
  logic                   period_end;
  logic                   accept;
  logic                   bad_ch;
  ch_state_t              ch_state [NUM_CH];

  assign tick       = enable && (presc == PRESC_LAST);
  assign period_end = tick && (cnt == '1);
  assign accept     = cfg_valid && cfg_ready;
  assign bad_ch     = 32'(cfg_ch) >= 32'(NUM_CH);

  // Prescaler and PWM counter; both hold their value while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

  // Handshake readiness, bad-channel flag and period strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready     <= 1'b0;
      cfg_err       <= 1'b0;
      period_strobe <= 1'b0;
    end else begin
      cfg_ready     <= 1'b1;
      cfg_err       <= accept && bad_ch;
      period_strobe <= period_end;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CHW-1:0] IDX = CHW'(i);

    rgb_fade_channel #(
      .PWM_WIDTH (PWM_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .period_end (period_end),
      .cnt        (cnt),
      .wr         (accept && (cfg_ch == IDX)),
      .wr_target  (cfg_target),
      .wr_step    (cfg_step),
      .pwm        (pwm_out[i]),
      .duty       (duty_out[i*PWM_WIDTH +: PWM_WIDTH]),
      .done       (done[i]),
      .state      (ch_state[i])
    );

    assign busy[i] = (ch_state[i] != ST_IDLE);
  end

endmodule
